// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 command scheduler: command encodings
// ({cs,ras,cas,we}), FSM state encodings and the request address split
// {bank[26:24], row[23:10], col[9:0]}.
package ddr3_pkg;

  localparam int ADDR_W = 27;
  localparam int BANK_W = 3;
  localparam int ROW_W  = 14;
  localparam int COL_W  = 10;

  typedef enum logic [3:0] {
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACT,
    ST_WAIT_RCD,
    ST_CAS,
    ST_WAIT_REC,
    ST_PRE,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC
  } state_e;

  function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] a);
    return a[26:24];
  endfunction

  function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
    return a[23:10];
  endfunction

  function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] a);
    return a[9:0];
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Refresh interval timer. Counts 0..T_REFI-1 once init_done is high (held at
// 0 before), raises ref_pend on every wrap and clears it when the scheduler
// issues REF (ref_clr). A wrap while a refresh is still owed sets the sticky
// ref_overrun flag.
// Ports: clk, rst (async, active-high), init_done, ref_clr -> ref_pend,
//        ref_overrun.
module ddr3_refresh_timer #(
  parameter int T_REFI = 3120
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
  input  logic ref_clr,
  output logic ref_pend,
  output logic ref_overrun
);

  localparam int TW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [TW-1:0] timer;
  logic          wrap;

  assign wrap = init_done && (timer == TW'(T_REFI - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (!init_done || wrap) timer <= '0;
      else                    timer <= timer + TW'(1);

      // A wrap in the same cycle as REF re-arms the request: the refresh
      // just issued covers the previous interval, not the new one.
      if (wrap) begin
        ref_pend <= 1'b1;
        if (ref_pend && !ref_clr) ref_overrun <= 1'b1;
      end else if (ref_clr) begin
        ref_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr3_cmd_sched.sv
// DDR3 command scheduler: one closed-page access at a time
// (ACT -> RD/WR -> PRE), round-robin between read and write requesters,
// periodic refresh between accesses. All command/address outputs are
// registered and reflect the state being occupied in that cycle.
// Ports: clk, rst (async, active-high), init_done,
//        rd_req/rd_addr, wr_req/wr_addr   request side (addr = {bank,row,col})
//        rd_ack/wr_ack                    one-cycle grant at the CAS cycle
//        cmd_out {cs,ras,cas,we}, ba_out, addr_out   DRAM command bus
//        rd_data_en/wr_data_en            datapath strobe at the CAS cycle
//        busy (not IDLE), ref_overrun (sticky missed refresh)
module ddr3_cmd_sched
  import ddr3_pkg::*;
#(
  parameter int T_RCD  = 6,
  parameter int T_RP   = 6,
  parameter int T_WR   = 8,
  parameter int T_RTP  = 4,
  parameter int T_RFC  = 64,
  parameter int T_REFI = 3120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_done,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic                rd_ack,
  output logic                wr_ack,
  output logic [3:0]          cmd_out,
  output logic [BANK_W-1:0]   ba_out,
  output logic [ROW_W-1:0]    addr_out,
  output logic                rd_data_en,
  output logic                wr_data_en,
  output logic                busy,
  output logic                ref_overrun
);

  localparam int MAXP = max2(max2(max2(T_RCD, T_RP), max2(T_WR, T_RTP)), T_RFC);
  localparam int CW   = $clog2(MAXP) + 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pref_wr_q, pref_wr_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic                lat_wr_q, lat_wr_d;
  logic                use_wr;
  logic                ref_pend;
  logic                ref_clr;

  assign ref_clr = (state_q == ST_REF);

  ddr3_refresh_timer #(.T_REFI(T_REFI)) u_refresh (
    .clk         (clk),
    .rst         (rst),
    .init_done   (init_done),
    .ref_clr     (ref_clr),
    .ref_pend    (ref_pend),
    .ref_overrun (ref_overrun)
  );

  // Write wins only if it is the sole requester or it is its turn.
  assign use_wr = wr_req && (!rd_req || pref_wr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pref_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pref_wr_q <= pref_wr_d;
    end
  end

  // Latched request is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    lat_addr_q <= lat_addr_d;
    lat_wr_q   <= lat_wr_d;
  end

  // Each wait state lasts T-1 cycles: the counter is loaded with T-2 and the
  // state exits on reaching zero; a parameter of 1 skips the wait state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pref_wr_d  = pref_wr_q;
    lat_addr_d = lat_addr_q;
    lat_wr_d   = lat_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (init_done) begin
          if (ref_pend) begin
            state_d = ST_REF;
          end else if (rd_req || wr_req) begin
            state_d    = ST_ACT;
            lat_wr_d   = use_wr;
            lat_addr_d = use_wr ? wr_addr : rd_addr;
            pref_wr_d  = !use_wr;
          end
        end
      end
      ST_ACT: begin
        if (T_RCD > 1) begin
          state_d = ST_WAIT_RCD;
          cnt_d   = CW'(T_RCD - 2);
        end else begin
          state_d = ST_CAS;
        end
      end
      ST_WAIT_RCD: begin
        if (cnt_q == '0) state_d = ST_CAS;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_CAS: begin
        if (lat_wr_q && T_WR > 1) begin
          state_d = ST_WAIT_REC;
          cnt_d   = CW'(T_WR - 2);
        end else if (!lat_wr_q && T_RTP > 1) begin
          state_d = ST_WAIT_REC;
          cnt_d   = CW'(T_RTP - 2);
        end else begin
          state_d = ST_PRE;
        end
      end
      ST_WAIT_REC: begin
        if (cnt_q == '0) state_d = ST_PRE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_PRE: begin
        if (T_RP > 1) begin
          state_d = ST_WAIT_RP;
          cnt_d   = CW'(T_RP - 2);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_REF: begin
        if (T_RFC > 1) begin
          state_d = ST_WAIT_RFC;
          cnt_d   = CW'(T_RFC - 2);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RFC: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command states last exactly one cycle, so keying on state_d issues each
  // command once. ba_out/addr_out keep their last value between commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_out    <= CMD_NOP;
      ba_out     <= '0;
      addr_out   <= '0;
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      rd_data_en <= 1'b0;
      wr_data_en <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cmd_out    <= CMD_NOP;
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      rd_data_en <= 1'b0;
      wr_data_en <= 1'b0;
      busy       <= (state_d != ST_IDLE);
      case (state_d)
        ST_ACT: begin
          cmd_out  <= CMD_ACT;
          ba_out   <= addr_bank(lat_addr_d);
          addr_out <= addr_row(lat_addr_d);
        end
        ST_CAS: begin
          cmd_out    <= lat_wr_q ? CMD_WR : CMD_RD;
          addr_out   <= {4'b0000, addr_col(lat_addr_q)};
          rd_ack     <= !lat_wr_q;
          wr_ack     <= lat_wr_q;
          rd_data_en <= !lat_wr_q;
          wr_data_en <= lat_wr_q;
        end
        ST_PRE: begin
          cmd_out      <= CMD_PRE;
          ba_out       <= addr_bank(lat_addr_q);
          addr_out[10] <= 1'b0;
        end
        ST_REF: cmd_out <= CMD_REF;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// Directed bench for ddr3_cmd_sched. Three instances share the clock:
//   0: default timing (basic access, round robin, reset abandon, init gate)
//   1: T_REFI=100, idle refresh cadence
//   2: T_REFI=10, T_RFC=4, continuous writes forcing refresh overrun
module tb_ddr3_cmd_sched;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        init_done  [3];
  logic        rd_req     [3];
  logic        wr_req     [3];
  logic [26:0] rd_addr    [3];
  logic [26:0] wr_addr    [3];
  logic        rd_ack     [3];
  logic        wr_ack     [3];
  logic [3:0]  cmd        [3];
  logic [2:0]  ba         [3];
  logic [13:0] addr       [3];
  logic        rd_data_en [3];
  logic        wr_data_en [3];
  logic        busy       [3];
  logic        ref_overrun[3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ddr3_cmd_sched #(
      .T_RFC  ((g == 2) ? 4 : 64),
      .T_REFI ((g == 0) ? 3120 : ((g == 1) ? 100 : 10))
    ) dut (
      .clk         (clk),
      .rst         (rst[g]),
      .init_done   (init_done[g]),
      .rd_req      (rd_req[g]),
      .wr_req      (wr_req[g]),
      .rd_addr     (rd_addr[g]),
      .wr_addr     (wr_addr[g]),
      .rd_ack      (rd_ack[g]),
      .wr_ack      (wr_ack[g]),
      .cmd_out     (cmd[g]),
      .ba_out      (ba[g]),
      .addr_out    (addr[g]),
      .rd_data_en  (rd_data_en[g]),
      .wr_data_en  (wr_data_en[g]),
      .busy        (busy[g]),
      .ref_overrun (ref_overrun[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance negedge by negedge until instance d shows a non-NOP command;
  // gap is the number of negedges stepped, or -1 if none within the bound.
  task automatic next_cmd(input int d, output int gap);
    gap = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (cmd[d] !== NOP) begin
        gap = i;
        return;
      end
    end
  endtask

  task automatic pulse_rst(input int d);
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, bad, refs, wrs, wr_pre_gap;
    logic in_acc, last_wr;
    logic exp_rd [3];
    exp_rd[0] = 1'b1; exp_rd[1] = 1'b0; exp_rd[2] = 1'b1;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; init_done[i] = 1'b0;
      rd_req[i] = 1'b0; wr_req[i] = 1'b0;
      rd_addr[i] = '0; wr_addr[i] = '0;
    end
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_cmd",  32'(cmd[0]), 32'(NOP));
    chk("rst_ba",   32'(ba[0]), 0);
    chk("rst_addr", 32'(addr[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_ack",  32'({rd_ack[0], wr_ack[0], rd_data_en[0], wr_data_en[0]}), 0);
    chk("rst_ovr",  32'(ref_overrun[0]), 0);
    rst[0] = 1'b0;

    // requests while init_done=0 are ignored
    rd_req[0] = 1'b1; wr_req[0] = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd[0] !== NOP || rd_ack[0] || wr_ack[0] || busy[0]) bad++;
    end
    chk("noinit_quiet", 32'(bad), 0);
    rd_req[0] = 1'b0; wr_req[0] = 1'b0;

    // single read: bank 2, row 0x155, col 0x008
    init_done[0] = 1'b1;
    rd_addr[0] = {3'd2, 14'h155, 10'h008};
    rd_req[0] = 1'b1;
    next_cmd(0, gap);
    chk("act_gap",  32'(gap), 1);
    chk("act_cmd",  32'(cmd[0]), 32'(ACT));
    chk("act_ba",   32'(ba[0]), 2);
    chk("act_row",  32'(addr[0]), 32'h155);
    chk("act_busy", 32'(busy[0]), 1);
    rd_req[0] = 1'b0;
    rd_addr[0] = '1;
    next_cmd(0, gap);
    chk("rd_gap",   32'(gap), 6);
    chk("rd_cmd",   32'(cmd[0]), 32'(RD));
    chk("rd_col",   32'(addr[0]), 32'h008);
    chk("rd_ba",    32'(ba[0]), 2);
    chk("rd_ack",   32'({rd_ack[0], rd_data_en[0], wr_ack[0], wr_data_en[0]}), 32'b1100);
    @(negedge clk);
    chk("rd_ack_pulse", 32'(rd_ack[0]), 0);
    chk("addr_hold",    32'(addr[0]), 32'h008);
    next_cmd(0, gap);
    chk("pre_gap",  32'(gap), 3);
    chk("pre_cmd",  32'(cmd[0]), 32'(PRE));
    chk("pre_ba",   32'(ba[0]), 2);
    chk("pre_a10",  32'(addr[0][10]), 0);
    repeat (5) @(negedge clk);
    chk("wait_rp_busy", 32'(busy[0]), 1);
    @(negedge clk);
    chk("idle_busy",    32'(busy[0]), 0);

    // round robin with both requesters held: rd, wr, rd
    pulse_rst(0);
    rd_addr[0] = {3'd1, 14'h0010, 10'h020};
    wr_addr[0] = {3'd5, 14'h03ff, 10'h03c};
    rd_req[0] = 1'b1; wr_req[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        next_cmd(0, gap);
        if (gap < 0 || cmd[0] === RD || cmd[0] === WR) break;
      end
      chk($sformatf("rr%0d_cmd", k), 32'(cmd[0]), exp_rd[k] ? 32'(RD) : 32'(WR));
      chk($sformatf("rr%0d_ack", k), 32'({rd_ack[0], wr_ack[0]}),
          exp_rd[k] ? 32'b10 : 32'b01);
      chk($sformatf("rr%0d_ba", k), 32'(ba[0]), exp_rd[k] ? 1 : 5);
    end
    rd_req[0] = 1'b0; wr_req[0] = 1'b0;

    // reset in WAIT_RCD abandons the access
    pulse_rst(0);
    rd_addr[0] = {3'd4, 14'h0aaa, 10'h155};
    rd_req[0] = 1'b1;
    next_cmd(0, gap);
    chk("abort_act", 32'(cmd[0]), 32'(ACT));
    rd_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("abort_cmd",  32'(cmd[0]), 32'(NOP));
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_ba",   32'(ba[0]), 0);
    rst[0] = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (cmd[0] !== NOP || rd_ack[0]) bad++;
    end
    chk("abort_no_cas", 32'(bad), 0);

    // idle refresh cadence with T_REFI=100
    rst[1] = 1'b0; init_done[1] = 1'b1;
    next_cmd(1, gap);
    chk("ref1_gap", 32'(gap), 101);
    chk("ref1_cmd", 32'(cmd[1]), 32'(REF));
    chk("ref1_busy", 32'(busy[1]), 1);
    next_cmd(1, gap);
    chk("ref2_gap", 32'(gap), 100);
    chk("ref2_cmd", 32'(cmd[1]), 32'(REF));
    next_cmd(1, gap);
    chk("ref3_gap", 32'(gap), 100);
    chk("ref3_cmd", 32'(cmd[1]), 32'(REF));
    chk("ref_no_overrun", 32'(ref_overrun[1]), 0);

    // continuous writes with T_REFI=10: refresh only between accesses
    wr_addr[2] = {3'd3, 14'h0022, 10'h011};
    wr_req[2] = 1'b1;
    rst[2] = 1'b0; init_done[2] = 1'b1;
    in_acc = 1'b0; last_wr = 1'b0;
    bad = 0; refs = 0; wrs = 0; wr_pre_gap = -1;
    for (int n = 0; n < 40; n++) begin
      next_cmd(2, gap);
      if (gap < 0) begin
        bad++;
        break;
      end
      if (last_wr && wr_pre_gap < 0) wr_pre_gap = (cmd[2] === PRE) ? gap : 0;
      last_wr = 1'b0;
      case (cmd[2])
        ACT: begin if (in_acc) bad++; in_acc = 1'b1; end
        WR:  begin if (!in_acc) bad++; wrs++; last_wr = 1'b1; end
        PRE: begin if (!in_acc) bad++; in_acc = 1'b0; end
        REF: begin if (in_acc) bad++; refs++; end
        default: bad++;
      endcase
    end
    chk("wr_pre_gap",   32'(wr_pre_gap), 8);
    chk("ref_ordering", 32'(bad), 0);
    chk("ref_seen",     32'(refs > 2), 1);
    chk("wr_seen",      32'(wrs > 2), 1);
    chk("ref_overrun",  32'(ref_overrun[2]), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ddr3_cmd_sched.md
DDR3_CMD_SCHED -- requirements
Module: ddr3_cmd_sched

Interface
REQ-001 SHALL have parameter T_RCD, default 6, ACT-to-CAS wait in clk cycles.
REQ-002 SHALL have parameter T_RP, default 6, PRE-to-next-command wait.
REQ-003 SHALL have parameter T_WR, default 8, WR-to-PRE recovery wait.
REQ-004 SHALL have parameter T_RTP, default 4, RD-to-PRE wait.
REQ-005 SHALL have parameter T_RFC, default 64, REF-to-next-command wait.
REQ-006 SHALL have parameter T_REFI, default 3120, refresh interval.
REQ-007 SHALL have port clk, input, 1, sole clock; reset is asynchronous and active-high.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port init_done, input, 1, device initialisation complete.
REQ-010 SHALL have ports rd_req and wr_req, input, 1 each, request level.
REQ-011 SHALL have ports rd_addr and wr_addr, input, 27 each, {bank[26:24], row[23:10], col[9:0]}.
REQ-012 SHALL have ports rd_ack and wr_ack, output, 1 each, one-cycle grant pulse.
REQ-013 SHALL have port cmd_out, output, 4, {cs,ras,cas,we}.
REQ-014 SHALL have ports ba_out (output, 3, bank) and addr_out (output, 14, row/column).
REQ-015 SHALL have ports rd_data_en and wr_data_en, output, 1 each, datapath strobe.
REQ-016 SHALL have ports busy (output, 1, not IDLE) and ref_overrun (output, 1, sticky missed-refresh flag).

Function
REQ-017 SHALL encode commands as NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001.
REQ-018 SHALL drive cmd_out=NOP in every cycle not issuing a command.
REQ-019 SHALL use states IDLE, ACT, WAIT_RCD, CAS, WAIT_REC, PRE, WAIT_RP, REF, WAIT_RFC.
REQ-020 SHALL stay in IDLE, no commands, refresh timer held at 0, while init_done=0.
REQ-021 SHALL count the refresh timer 0..T_REFI-1 after init_done; at wrap it sets ref_pend.
REQ-022 SHALL set ref_overrun if the timer wraps while ref_pend is already 1.
REQ-023 SHALL, from IDLE, give ref_pend priority over requests (-> REF).
REQ-024 SHALL otherwise grant round-robin: both requesting -> side not granted last; one -> that side; after reset rd first.
REQ-025 SHALL latch the winner's address and direction at IDLE exit; the input may change afterwards.
REQ-026 SHALL issue ACT with ba_out=bank, addr_out=row, then wait T_RCD-1 NOP cycles in WAIT_RCD.
REQ-027 SHALL issue RD/WR in CAS with addr_out={4'b0, col}; A10=0; pulse rd_ack or wr_ack and rd_data_en or wr_data_en in the same cycle.
REQ-028 SHALL wait T_RTP-1 (read) or T_WR-1 (write) cycles in WAIT_REC.
REQ-029 SHALL issue PRE with ba_out=latched bank, A10=0, then wait T_RP-1 cycles in WAIT_RP, then go to IDLE.
REQ-030 SHALL issue REF, clear ref_pend in that cycle, wait T_RFC-1 cycles, then go to IDLE.
REQ-031 SHALL let a wrap coinciding with the REF cycle leave ref_pend set, not overrun.
REQ-032 SHALL never abort an access for refresh; refresh waits for the next IDLE.
REQ-033 SHALL hold ba_out/addr_out between commands.
REQ-034 SHALL use one down-counter for all waits, width ceil(log2(max parameter))+1.

Reset
REQ-035 SHALL, on rst, set state IDLE, cmd_out=0111, ba_out=0, addr_out=0, all acks/strobes 0, busy=0, ref_pend=0, ref_overrun=0, timer 0, round-robin pointer rd.
REQ-036 SHALL treat rst mid-access as abandon: no further command issued.

Structure
REQ-037 SHALL place command encodings, state encodings and the address field split in a shared ddr3_pkg package.
REQ-038 SHALL contain one sub-module, ddr3_refresh_timer (timer, ref_pend, ref_overrun, REF clear input).

Verification
REQ-039 SHALL cover: init_done=1, rd_req addr bank2/row 0x155/col 0x08 -> ACT(ba2,0x155), RD 6 cycles later (addr 0x008, rd_ack), PRE 4 cycles after RD.
REQ-040 SHALL cover: rd_req and wr_req together, held -> grants alternate rd, wr, rd.
REQ-041 SHALL cover: T_REFI=100, no requests -> REF every 100 cycles, ref_overrun=0.
REQ-042 SHALL cover: T_REFI=10 with continuous write traffic -> REF between accesses, ref_overrun=1.
REQ-043 SHALL cover: rst asserted during WAIT_RCD -> cmd_out=0111 next edge, no CAS, busy=0.
REQ-044 SHALL cover: init_done=0 with requests -> no ack, cmd_out NOP.
